// File: rtl/spi_txn_arbiter_pkg.sv
// Shared types and constants for the SPI transaction arbiter: FSM state
// encoding, default length width and operation encodings.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_START,
    ST_WAIT_BUSY,
    ST_RUN,
    ST_DONE
  } arb_state_t;

  localparam int LEN_W_DEF = 16;

  localparam logic OP_WR = 1'b0;
  localparam logic OP_RD = 1'b1;

endpackage

// File: rtl/spi_txn_arbiter_if.sv
// Requester-side bundle of the SPI arbiter: per-requester request/start,
// TX/RX byte strobes, and the grant/completion signals returned to them.
interface spi_txn_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int DATA  = 8,
  parameter int LEN_W = LEN_W_DEF
);

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_start;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ-1:0]       req_op;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  err;
  logic [NREQ*DATA-1:0]  req_wdata;
  logic [NREQ-1:0]       req_wr;
  logic [NREQ-1:0]       req_full;
  logic [DATA-1:0]       req_rdata;
  logic [NREQ-1:0]       req_rd;
  logic [NREQ-1:0]       req_empty;

  // Requester FSMs drive requests and byte strobes.
  modport master (
    output req, req_start, req_len, req_op, req_wdata, req_wr, req_rd,
    input  gnt, done, err, req_full, req_rdata, req_empty
  );

  // The arbiter answers with grant, completion and steered FIFO status.
  modport slave (
    input  req, req_start, req_len, req_op, req_wdata, req_wr, req_rd,
    output gnt, done, err, req_full, req_rdata, req_empty
  );

endinterface

// File: rtl/spi_txn_arbiter_rr.sv
// Round-robin picker: searches from the index after the last winner and
// remembers the winner when the caller accepts the grant.
module rr_arbiter
#(
  parameter  int NREQ  = 2,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             accept,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W:0]   cand;

  always_comb begin
    gnt  = '0;
    idx  = ptr_reg;
    any  = 1'b0;
    cand = '0;
    // Offset NREQ wraps back to the previous winner, so it is checked last.
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, ptr_reg} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NREQ)) begin
        cand = cand - (IDX_W+1)'(NREQ);
      end
      if (!any && req[cand[IDX_W-1:0]]) begin
        any = 1'b1;
        idx = cand[IDX_W-1:0];
      end
    end
    if (any) begin
      gnt[idx] = 1'b1;
    end
  end

  // Starting at NREQ-1 makes requester 0 the first winner out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= IDX_W'(NREQ - 1);
    end else if (accept && any) begin
      ptr_reg <= idx;
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI transaction engine and its TX/RX FIFOs between NREQ
// requesters: grants one at a time, launches work, tracks busy and timeouts.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int DATA    = 8,
  parameter int NREQ    = 2,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int BUSY_TO = 1024
) (
  input  logic             clk,
  input  logic             rst,
  spi_txn_arbiter_if.slave bus,
  output logic [DATA-1:0]  wdata,
  output logic             wr,
  input  logic             full,
  input  logic [DATA-1:0]  rdata,
  output logic             rd,
  input  logic             empty,
  output logic [LEN_W-1:0] len,
  output logic             op,
  output logic             work,
  input  logic             busy
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(BUSY_TO + 1);
  localparam logic [CNT_W-1:0] CNT_TO = CNT_W'(BUSY_TO);

  arb_state_t       state_reg, state_next;
  logic [NREQ-1:0]  gnt_reg, gnt_next;
  logic [NREQ-1:0]  done_reg, done_next;
  logic [IDX_W-1:0] owner_reg, owner_next;
  logic             err_reg, err_next;
  logic             work_reg, work_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic             op_reg, op_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;

  logic [NREQ-1:0]  arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;
  logic             arb_accept;

  logic [DATA-1:0]  wdata_arr [NREQ];
  logic [LEN_W-1:0] len_arr   [NREQ];

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req),
    .accept (arb_accept),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  // Per-requester unpacking and FIFO status steering; non-owners see a
  // permanently full TX FIFO and an empty RX FIFO.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign wdata_arr[gi]     = bus.req_wdata[gi*DATA +: DATA];
    assign len_arr[gi]       = bus.req_len[gi*LEN_W +: LEN_W];
    assign bus.req_full[gi]  = gnt_reg[gi] ? full  : 1'b1;
    assign bus.req_empty[gi] = gnt_reg[gi] ? empty : 1'b1;
  end

  assign wdata         = wdata_arr[owner_reg];
  assign wr            = bus.req_wr[owner_reg] & gnt_reg[owner_reg];
  assign rd            = bus.req_rd[owner_reg] & gnt_reg[owner_reg] & ~empty;
  assign bus.req_rdata = rdata;

  assign bus.gnt  = gnt_reg;
  assign bus.done = done_reg;
  assign bus.err  = err_reg;
  assign len      = len_reg;
  assign op       = op_reg;
  assign work     = work_reg;

  assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    owner_next = owner_reg;
    done_next  = '0;
    err_next   = 1'b0;
    work_next  = 1'b0;
    len_next   = len_reg;
    op_next    = op_reg;
    cnt_next   = cnt_reg;
    arb_accept = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (arb_any) begin
          arb_accept = 1'b1;
          gnt_next   = arb_gnt;
          owner_next = arb_idx;
          state_next = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (bus.req_start[owner_reg]) begin
          len_next = len_arr[owner_reg];
          op_next  = bus.req_op[owner_reg];
          // A zero-length transaction never reaches the engine.
          if (len_arr[owner_reg] == '0) begin
            done_next  = gnt_reg;
            err_next   = 1'b1;
            state_next = ST_DONE;
          end else begin
            work_next  = 1'b1;
            state_next = ST_START;
          end
        end else if (!bus.req[owner_reg]) begin
          gnt_next   = '0;
          state_next = ST_IDLE;
        end
      end

      ST_START: begin
        cnt_next   = '0;
        state_next = ST_WAIT_BUSY;
      end

      ST_WAIT_BUSY: begin
        if (busy) begin
          state_next = ST_RUN;
        end else if (cnt_inc == CNT_TO) begin
          done_next  = gnt_reg;
          err_next   = 1'b1;
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      ST_RUN: begin
        if (!busy) begin
          done_next  = gnt_reg;
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        gnt_next   = '0;
        state_next = ST_IDLE;
      end

      default: begin
        gnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      gnt_reg   <= '0;
      done_reg  <= '0;
      owner_reg <= '0;
      err_reg   <= 1'b0;
      work_reg  <= 1'b0;
      len_reg   <= '0;
      op_reg    <= OP_WR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      done_reg  <= done_next;
      owner_reg <= owner_next;
      err_reg   <= err_next;
      work_reg  <= work_next;
      len_reg   <= len_next;
      op_reg    <= op_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: single transfer, contention,
// isolation, busy timeout, zero length, grant drop and mid-run reset.
module tb_spi_txn_arbiter;
  import spi_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int DATA = 8;
  localparam int LW   = 16;
  localparam int BTO  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_txn_arbiter_if #(.NREQ(NREQ), .DATA(DATA), .LEN_W(LW)) bus ();

  logic [DATA-1:0] wdata, rdata;
  logic            wr, full, rd, empty, op, work, busy;
  logic [LW-1:0]   len;

  spi_txn_arbiter #(.DATA(DATA), .NREQ(NREQ), .LEN_W(LW), .BUSY_TO(BTO)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .wdata (wdata),
    .wr    (wr),
    .full  (full),
    .rdata (rdata),
    .rd    (rd),
    .empty (empty),
    .len   (len),
    .op    (op),
    .work  (work),
    .busy  (busy)
  );

  int checks   = 0;
  int failures = 0;
  int work_cnt = 0;
  int busy_en, bdelay, bhold;
  logic [DATA-1:0] tx_q[$];

  // TX FIFO and work-pulse monitors.
  always @(posedge clk) begin
    if (wr) tx_q.push_back(wdata);
    if (work) work_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  // Advance to the next negedge; busy model rises 2 cycles after work, holds 24.
  task automatic tick();
    @(negedge clk);
    if (busy_en != 0) begin
      if (work) begin
        bdelay = 2;
      end else if (bdelay > 0) begin
        bdelay--;
        if (bdelay == 0) begin
          busy  = 1'b1;
          bhold = 24;
        end
      end else if (bhold > 0) begin
        bhold--;
        if (bhold == 0) busy = 1'b0;
      end
    end
  endtask

  task automatic start_txn(input int who, input logic [LW-1:0] l, input logic o);
    bus.req_len[who*LW +: LW] = l;
    bus.req_op[who]           = o;
    bus.req_start[who]        = 1'b1;
    tick();
    bus.req_start[who]        = 1'b0;
  endtask

  task automatic wait_done(input int who, output int cycles, output logic seen, output logic errv);
    seen   = 1'b0;
    errv   = 1'b0;
    cycles = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      cycles++;
      if (bus.done[who]) begin
        seen = 1'b1;
        errv = bus.err;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int   cyc, w0, qn;
    logic seen, errv;

    rst = 1'b1;
    bus.req = '0; bus.req_start = '0; bus.req_len = '0; bus.req_op = '0;
    bus.req_wdata = '0; bus.req_wr = '0; bus.req_rd = '0;
    full = 1'b0; rdata = '0; empty = 1'b1; busy = 1'b0;
    busy_en = 0; bdelay = 0; bhold = 0;
    repeat (3) tick();

    check("rst_gnt",  32'(bus.gnt), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_err",  32'(bus.err), 0);
    check("rst_work", 32'(work), 0);
    check("rst_len",  32'(len), 0);
    check("rst_op",   32'(op), 0);
    rst = 1'b0;

    // Single requester, 3-byte write.
    busy_en = 1;
    bus.req = 2'b01;
    tick();
    check("t1_gnt", 32'(bus.gnt), 32'h1);
    for (int i = 0; i < 3; i++) begin
      bus.req_wdata[7:0] = DATA'(8'hA1 + i);
      bus.req_wr[0]      = 1'b1;
      #1;
      if (i == 0) begin
        check("t1_wr", 32'(wr), 1);
        check("t1_wdata", 32'(wdata), 32'hA1);
      end
      tick();
    end
    bus.req_wr[0] = 1'b0;
    w0 = work_cnt;
    start_txn(0, 16'd3, OP_WR);
    check("t1_work", 32'(work), 1);
    check("t1_len", 32'(len), 3);
    check("t1_op", 32'(op), 0);
    wait_done(0, cyc, seen, errv);
    check("t1_done", 32'(seen), 1);
    check("t1_err", 32'(errv), 0);
    check("t1_len_hold", 32'(len), 3);
    check("t1_work_cnt", 32'(work_cnt - w0), 1);
    check("t1_tx_n", 32'(tx_q.size()), 3);
    if (tx_q.size() == 3) check("t1_tx_data", {8'h0, tx_q[0], tx_q[1], tx_q[2]}, 32'hA1A2A3);
    bus.req = 2'b00;
    tick();
    check("t1_gnt_clr", 32'(bus.gnt), 0);

    // Contention from reset plus isolation of the non-owner.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = 2'b11;
    tick();
    check("t2_gnt_a", 32'(bus.gnt), 32'h1);
    bus.req_wr[1] = 1'b1; bus.req_rd[1] = 1'b1; bus.req_wdata[15:8] = 8'h77;
    empty = 1'b0; rdata = 8'h5C;
    #1;
    check("iso_wr", 32'(wr), 0);
    check("iso_rd", 32'(rd), 0);
    check("iso_full1", 32'(bus.req_full[1]), 1);
    check("iso_empty1", 32'(bus.req_empty[1]), 1);
    check("iso_full0", 32'(bus.req_full[0]), 0);
    check("iso_empty0", 32'(bus.req_empty[0]), 0);
    check("rdata_bcast", 32'(bus.req_rdata), 32'h5C);
    bus.req_rd[0] = 1'b1;
    #1;
    check("owner_rd", 32'(rd), 1);
    empty = 1'b1;
    #1;
    check("owner_rd_empty", 32'(rd), 0);
    qn = tx_q.size();
    tick();
    check("iso_no_push", 32'(tx_q.size()), 32'(qn));
    bus.req_wr = '0; bus.req_rd = '0;

    start_txn(0, 16'd2, OP_WR);
    wait_done(0, cyc, seen, errv);
    check("t2_done_a", 32'(seen), 1);
    tick(); tick();
    check("t2_gnt_b", 32'(bus.gnt), 32'h2);
    start_txn(1, 16'd2, OP_RD);
    wait_done(1, cyc, seen, errv);
    check("t2_done_b", 32'(seen), 1);
    check("t2_err_b", 32'(errv), 0);
    tick(); tick();
    check("t2_gnt_c", 32'(bus.gnt), 32'h1);

    // Busy never rises: timeout after BUSY_TO cycles.
    busy_en = 0;
    start_txn(0, 16'd5, OP_WR);
    check("t3_work", 32'(work), 1);
    wait_done(0, cyc, seen, errv);
    check("t3_done", 32'(seen), 1);
    check("t3_cycles", 32'(cyc), 17);
    check("t3_err", 32'(errv), 1);
    bus.req = 2'b10;
    tick();
    check("t3_gnt_clr", 32'(bus.gnt), 0);
    tick();
    check("t4_gnt", 32'(bus.gnt), 32'h2);

    // Zero-length start aborts without a work pulse.
    w0 = work_cnt;
    start_txn(1, 16'd0, OP_WR);
    check("t4_done", 32'(bus.done), 32'h2);
    check("t4_err", 32'(bus.err), 1);
    check("t4_work", 32'(work), 0);
    tick();
    check("t4_nowork", 32'(work_cnt - w0), 0);
    check("t4_err_clr", 32'(bus.err), 0);

    // Owner drops request without starting.
    bus.req = 2'b11;
    tick();
    check("t5_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 2'b10;
    tick();
    check("t5_drop", 32'(bus.gnt), 0);
    tick();
    check("t5_other", 32'(bus.gnt), 32'h2);

    // Reset while the engine is running.
    busy_en = 1;
    start_txn(1, 16'd4, OP_RD);
    check("t6_op", 32'(op), 1);
    for (int i = 0; i < 5; i++) tick();
    check("t6_busy", 32'(busy), 1);
    bus.req_wr[1] = 1'b1; bus.req_rd[1] = 1'b1; empty = 1'b0;
    rst = 1'b1;
    tick();
    check("t6_gnt", 32'(bus.gnt), 0);
    check("t6_done", 32'(bus.done), 0);
    check("t6_err", 32'(bus.err), 0);
    check("t6_work", 32'(work), 0);
    check("t6_len", 32'(len), 0);
    check("t6_op_rst", 32'(op), 0);
    check("t6_wr", 32'(wr), 0);
    check("t6_rd", 32'(rd), 0);
    bus.req_wr = '0; bus.req_rd = '0; empty = 1'b1;
    busy = 1'b0; bdelay = 0; bhold = 0;
    rst = 1'b0;
    bus.req = 2'b10;
    tick();
    check("t6_regrant", 32'(bus.gnt), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
